// File: rtl/path_launch_capture_if.sv
// Launch/capture harness bus: run control, path drive/sample and run status.
// The master side (bench/host) drives start, num_tests and capture_i; the
// slave side (the harness) drives the rest.
interface path_launch_capture_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] num_tests;
  logic             launch_o;
  logic             capture_i;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] test_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output start, num_tests, capture_i,
    input  launch_o, busy, done, pass, test_cnt, err_cnt
  );

  modport slave (
    input  start, num_tests, capture_i,
    output launch_o, busy, done, pass, test_cnt, err_cnt
  );
endinterface

// File: rtl/path_launch_capture.sv
// Register-to-register launch/capture wrapper around an inverting comb path.
// A launch flop drives the path, a capture compare runs CAPTURE_LAT edges
// later, and mismatches against the expected polarity are counted.
// Optional macro PATH_LFSR_EN: pattern from an 8-bit Fibonacci LFSR
// (x^8+x^6+x^5+x^4+1, seed 8'hA5) instead of a plain toggle.
module path_launch_capture #(
  parameter bit INV_PARITY  = 1'b1,
  parameter int CAPTURE_LAT = 1,
  parameter int CNT_W       = 16
) (
  input logic              clk,
  input logic              rst_n,
  path_launch_capture_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

  state_t           r_state;
  logic [3:0]       r_wait;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_test_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_launch;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic             w_cmp_edge;
  logic             w_mis;
  logic [CNT_W-1:0] w_test_nxt;
  logic [CNT_W-1:0] w_err_nxt;
  logic             w_pat;

  // Compare happens on the last WAIT edge; capture_i is ignored otherwise.
  assign w_cmp_edge = (r_state == WAIT) && (r_wait == 4'd1);
  assign w_mis      = bus.capture_i != (r_launch ^ INV_PARITY);
  assign w_test_nxt = r_test_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_err_nxt  = r_err_cnt + {{(CNT_W-1){1'b0}}, w_mis};

`ifdef PATH_LFSR_EN
  logic [7:0] r_lfsr;
  logic       w_fb;

  // Taps 8,6,5,4; the new bit enters at lfsr[0] and is the launched value.
  assign w_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_pat = w_fb;

  // Pattern generator: reseeded on reset and every accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_lfsr <= 8'hA5;
    else if (r_state == IDLE && bus.start)       r_lfsr <= 8'hA5;
    else if (r_state == LAUNCH)                  r_lfsr <= {r_lfsr[6:0], w_fb};
  end
`else
  assign w_pat = ~r_launch;
`endif

  // Run controller: all status outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wait     <= '0;
      r_num      <= '0;
      r_test_cnt <= '0;
      r_err_cnt  <= '0;
      r_launch   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_num      <= bus.num_tests;
            r_test_cnt <= '0;
            r_err_cnt  <= '0;
            r_busy     <= 1'b1;
            if (bus.num_tests != '0) begin
              r_state <= LAUNCH;
            end else begin
              // Empty run: nothing compared, so it trivially passes.
              r_state <= DONE;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          r_launch <= w_pat;
          r_wait   <= 4'(CAPTURE_LAT);
          r_state  <= WAIT;
        end
        WAIT: begin
          r_wait <= r_wait - 4'd1;
          if (w_cmp_edge) begin
            r_test_cnt <= w_test_nxt;
            r_err_cnt  <= w_err_nxt;
            if (w_test_nxt == r_num) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_pass  <= (w_err_nxt == '0);
            end else begin
              r_state <= LAUNCH;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.launch_o = r_launch;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.pass     = r_pass;
  assign bus.test_cnt = r_test_cnt;
  assign bus.err_cnt  = r_err_cnt;
endmodule
